etc_toll_logger: RTL and testbench

//  Downstream consumer of non_stop_ETC. On each measurement-complete pulse it captures speed and barrier state.
//  It classifies overspeed and computes the toll plus fine, then buffers a transaction record.

---
 rtl/etc_pkg.sv | 30 +++
 rtl/etc_rec_fifo.sv | 79 +++++++
 rtl/etc_toll_logger.sv | 169 ++++++++++++++++
 tb/tb_etc_toll_logger.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/etc_pkg.sv
// Shared types and constants for the ETC toll logger: FSM encoding,
// record layout at the default widths and the drop-counter width.
package etc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CALC  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   localparam int unsigned DROP_W          = 8;
   localparam int unsigned DEF_WIDTH_SPEED = 14;
   localparam int unsigned DEF_WIDTH_FEE   = 16;
   localparam int unsigned DEF_WIDTH_SEQ   = 8;

   // Record is {seq, paid, over, fee, speed}, speed in the LSBs
   function automatic int unsigned rec_width(input int unsigned w_speed,
                                             input int unsigned w_fee,
                                             input int unsigned w_seq);
      return w_seq + 2 + w_fee + w_speed;
   endfunction

   localparam int unsigned REC_W_DEF = rec_width(DEF_WIDTH_SPEED, DEF_WIDTH_FEE, DEF_WIDTH_SEQ);
   localparam int unsigned OFF_SPEED = 0;
   localparam int unsigned OFF_FEE   = OFF_SPEED + DEF_WIDTH_SPEED;
   localparam int unsigned OFF_OVER  = OFF_FEE + DEF_WIDTH_FEE;
   localparam int unsigned OFF_PAID  = OFF_OVER + 1;
   localparam int unsigned OFF_SEQ   = OFF_PAID + 1;

endpackage

// File: rtl/etc_rec_fifo.sv
// Synchronous record FIFO with a registered head output. The head register
// is reloaded on every push/pop so o_dout always shows the oldest entry.
module etc_rec_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned REC_W = 40,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [REC_W-1:0] i_din,
   output logic [REC_W-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [REC_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             r_full;
   logic             r_empty;
   logic [REC_W-1:0] r_dout;

   logic             w_do_pop;
   logic             w_do_push;
   logic [CW-1:0]    w_count_nxt;
   logic [CW-1:0]    w_stay;
   logic [AW-1:0]    w_rd_nxt;
   logic [REC_W-1:0] w_dout_nxt;

   // Qualify requests and work out the head entry after this cycle
   always_comb begin
      w_do_pop    = i_pop & ~r_empty;
      w_do_push   = i_push & (~r_full | w_do_pop);
      w_count_nxt = r_count + CW'(w_do_push) - CW'(w_do_pop);
      w_stay      = r_count - CW'(w_do_pop);
      w_rd_nxt    = r_rd + AW'(w_do_pop);
      w_dout_nxt  = r_dout;
      if (w_stay == '0) begin
         if (w_do_push) w_dout_nxt = i_din;
      end else begin
         w_dout_nxt = r_mem[w_rd_nxt];
      end
   end

   // Storage array, written only on an accepted push
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= i_din;
   end

   // Pointers, occupancy and registered head/flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_dout  <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + AW'(1);
         r_rd    <= w_rd_nxt;
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == '0);
         r_dout  <= w_dout_nxt;
      end
   end

   assign o_dout  = r_dout;
   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_count = r_count;

endmodule

// File: rtl/etc_toll_logger.sv
// ETC toll logger: captures speed/barrier on done, computes overspeed and
// fee, and queues a {seq, paid, over, fee, speed} record for the host.
// Optional feature macro ETC_STATS_EN adds cnt_total / cnt_unpaid counters.
module etc_toll_logger
   import etc_pkg::*;
#(
   parameter int unsigned WIDTH_SPEED = DEF_WIDTH_SPEED,
   parameter int unsigned WIDTH_FEE   = DEF_WIDTH_FEE,
   parameter int unsigned SPEED_LIMIT = 80,
   parameter int unsigned BASE_FEE    = 25,
   parameter int unsigned FINE        = 500,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned WIDTH_SEQ   = DEF_WIDTH_SEQ,
   localparam int unsigned REC_W      = rec_width(WIDTH_SPEED, WIDTH_FEE, WIDTH_SEQ)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   done,
   input  logic [WIDTH_SPEED-1:0] speed,
   input  logic                   barrier,
   output logic                   rec_valid,
   input  logic                   rec_ready,
   output logic [REC_W-1:0]       rec_data,
   output logic                   full,
   output logic [DROP_W-1:0]      drop_cnt
`ifdef ETC_STATS_EN
   ,output logic [15:0]           cnt_total
   ,output logic [15:0]           cnt_unpaid
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [WIDTH_SPEED-1:0] r_speed;
   logic                   r_barrier;
   logic                   r_over;
   logic                   r_paid;
   logic [WIDTH_FEE-1:0]   r_fee;
   logic [WIDTH_SEQ-1:0]   r_seq;
   logic [DROP_W-1:0]      r_drop;

   logic                   w_capture;
   logic                   w_calc;
   logic                   w_write;
   logic                   w_late_done;
   logic                   w_over;
   logic                   w_pop;
   logic                   w_push;
   logic [1:0]             w_drop_inc;
   logic [DROP_W:0]        w_drop_sum;
   logic [REC_W-1:0]       w_rec;
   logic [REC_W-1:0]       w_dout;
   logic                   w_full;
   logic                   w_empty;
   logic [CNT_W-1:0]       w_count;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state and per-state strobes; done outside IDLE is a lost event
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_calc      = 1'b0;
      w_write     = 1'b0;
      w_late_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (done) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_CALC;
            end
         end
         ST_CALC: begin
            w_calc      = 1'b1;
            w_late_done = done;
            w_state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            w_write     = 1'b1;
            w_late_done = done;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Push gating, drop accounting and record assembly
   always_comb begin
      w_over     = (r_speed > WIDTH_SPEED'(SPEED_LIMIT));
      w_pop      = rec_valid & rec_ready;
      w_push     = w_write & ((w_count != CNT_W'(DEPTH)) | w_pop);
      w_drop_inc = {1'b0, w_write & ~w_push} + {1'b0, w_late_done};
      w_drop_sum = {1'b0, r_drop} + (DROP_W + 1)'(w_drop_inc);
      w_rec      = {r_seq, r_paid, r_over, r_fee, r_speed};
   end

   // Capture, fee calculation, sequence and drop counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_speed   <= '0;
         r_barrier <= 1'b0;
         r_over    <= 1'b0;
         r_paid    <= 1'b0;
         r_fee     <= '0;
         r_seq     <= '0;
         r_drop    <= '0;
      end else begin
         if (w_capture) begin
            r_speed   <= speed;
            r_barrier <= barrier;
         end
         if (w_calc) begin
            r_over <= w_over;
            r_paid <= ~r_barrier;
            r_fee  <= WIDTH_FEE'(BASE_FEE) + (w_over ? WIDTH_FEE'(FINE) : '0);
         end
         if (w_push) r_seq <= r_seq + WIDTH_SEQ'(1);
         r_drop <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
      end
   end

   etc_rec_fifo #(
      .DEPTH (DEPTH),
      .REC_W (REC_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_din   (w_rec),
      .o_dout  (w_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign rec_valid = ~w_empty;
   assign rec_data  = w_dout;
   assign full      = w_full;
   assign drop_cnt  = r_drop;

`ifdef ETC_STATS_EN
   logic [15:0] r_cnt_total;
   logic [15:0] r_cnt_unpaid;

   // Event statistics: every captured done, and those with barrier closed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt_total  <= '0;
         r_cnt_unpaid <= '0;
      end else if (w_capture) begin
         r_cnt_total <= r_cnt_total + 16'd1;
         if (barrier) r_cnt_unpaid <= r_cnt_unpaid + 16'd1;
      end
   end

   assign cnt_total  = r_cnt_total;
   assign cnt_unpaid = r_cnt_unpaid;
`else
   // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_etc_toll_logger.sv
// Directed bench for etc_toll_logger (default parameters, 20 ns clock).
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_etc_toll_logger;

   logic        clk = 1'b0;
   logic        reset;
   logic        done;
   logic [13:0] speed;
   logic        barrier;
   logic        rec_valid;
   logic        rec_ready;
   logic [39:0] rec_data;
   logic        full;
   logic [7:0]  drop_cnt;
`ifdef ETC_STATS_EN
   logic [15:0] cnt_total;
   logic [15:0] cnt_unpaid;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   logic [39:0] exp_q [4];

   etc_toll_logger dut (
      .clk       (clk),
      .reset     (reset),
      .done      (done),
      .speed     (speed),
      .barrier   (barrier),
      .rec_valid (rec_valid),
      .rec_ready (rec_ready),
      .rec_data  (rec_data),
      .full      (full),
      .drop_cnt  (drop_cnt)
`ifdef ETC_STATS_EN
      ,.cnt_total  (cnt_total)
      ,.cnt_unpaid (cnt_unpaid)
`endif
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [39:0] rec(input int seq, input bit paid, input bit over,
                                       input int fee, input int spd);
      return {8'(seq), paid, over, 16'(fee), 14'(spd)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      done      = 1'b0;
      rec_ready = 1'b0;
      speed     = '0;
      barrier   = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // done high for one cycle; returns one cycle later (cycle 1)
   task automatic pulse(input int spd, input bit br);
      done    = 1'b1;
      speed   = 14'(spd);
      barrier = br;
      tick();
      done = 1'b0;
   endtask

   // pulse then idle so the FSM is back in IDLE
   task automatic send(input int spd, input bit br);
      pulse(spd, br);
      repeat (9) tick();
   endtask

   task automatic fill4();
      send(10, 1'b0);
      send(90, 1'b1);
      send(80, 1'b0);
      send(200, 1'b1);
   endtask

   initial begin
      exp_q[0] = rec(0, 1'b1, 1'b0, 25, 10);
      exp_q[1] = rec(1, 1'b0, 1'b1, 525, 90);
      exp_q[2] = rec(2, 1'b1, 1'b0, 25, 80);
      exp_q[3] = rec(3, 1'b0, 1'b1, 525, 200);

      do_reset();
      check_eq("rst_valid", 64'(rec_valid), 64'd0);
      check_eq("rst_data",  64'(rec_data),  64'd0);
      check_eq("rst_full",  64'(full),      64'd0);
      check_eq("rst_drop",  64'(drop_cnt),  64'd0);

      // Basic latency and record contents
      rec_ready = 1'b1;
      pulse(60, 1'b0);
      check_eq("t1_valid_c1", 64'(rec_valid), 64'd0);
      tick();
      check_eq("t1_valid_c2", 64'(rec_valid), 64'd0);
      tick();
      check_eq("t1_valid_c3", 64'(rec_valid), 64'd1);
      check_eq("t1_data", 64'(rec_data), 64'(rec(0, 1'b1, 1'b0, 25, 60)));
      tick();
      check_eq("t1_popped", 64'(rec_valid), 64'd0);

      // Overspeed with barrier closed, then the exact limit
      pulse(81, 1'b1);
      tick();
      tick();
      check_eq("t2_over_data", 64'(rec_data), 64'(rec(1, 1'b0, 1'b1, 525, 81)));
      tick();
      pulse(80, 1'b0);
      tick();
      tick();
      check_eq("t2_limit_data", 64'(rec_data), 64'(rec(2, 1'b1, 1'b0, 25, 80)));
      tick();
`ifdef ETC_STATS_EN
      check_eq("stats_total",  64'(cnt_total),  64'd3);
      check_eq("stats_unpaid", 64'(cnt_unpaid), 64'd1);
`endif

      // Fill to full, fifth record dropped, then drain in order
      do_reset();
      fill4();
      check_eq("t3_full4", 64'(full),     64'd1);
      check_eq("t3_drop4", 64'(drop_cnt), 64'd0);
      send(55, 1'b0);
      check_eq("t3_drop5", 64'(drop_cnt), 64'd1);
      check_eq("t3_full5", 64'(full),     64'd1);
      rec_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("t3_drain%0d", i), 64'(rec_data), 64'(exp_q[i]));
         tick();
      end
      rec_ready = 1'b0;
      check_eq("t3_empty", 64'(rec_valid), 64'd0);
      check_eq("t3_notfull", 64'(full), 64'd0);

      // Pop in the WRITE cycle frees room for the fifth record
      do_reset();
      fill4();
      pulse(33, 1'b0);
      tick();
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
      check_eq("t4_drop", 64'(drop_cnt), 64'd0);
      check_eq("t4_full", 64'(full),     64'd1);
      rec_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         check_eq($sformatf("t4_drain%0d", i), 64'(rec_data), 64'(exp_q[i]));
         tick();
      end
      check_eq("t4_drain4", 64'(rec_data), 64'(rec(4, 1'b1, 1'b0, 25, 33)));
      tick();
      rec_ready = 1'b0;
      check_eq("t4_empty", 64'(rec_valid), 64'd0);

      // done held two cycles: second one lands in CALC and is lost
      do_reset();
      done    = 1'b1;
      speed   = 14'd70;
      barrier = 1'b0;
      tick();
      speed   = 14'd100;
      barrier = 1'b1;
      tick();
      done = 1'b0;
      tick();
      check_eq("t5_valid", 64'(rec_valid), 64'd1);
      check_eq("t5_data",  64'(rec_data),  64'(rec(0, 1'b1, 1'b0, 25, 70)));
      check_eq("t5_drop",  64'(drop_cnt),  64'd1);
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
      repeat (4) tick();
      check_eq("t5_single", 64'(rec_valid), 64'd0);
      check_eq("t5_drop_hold", 64'(drop_cnt), 64'd1);

      // Reset in the WRITE cycle clears everything and loses the capture
      send(120, 1'b0);
      check_eq("t6_pre_valid", 64'(rec_valid), 64'd1);
      pulse(45, 1'b1);
      tick();
      reset = 1'b1;
      #1;
      check_eq("t6_rst_valid", 64'(rec_valid), 64'd0);
      check_eq("t6_rst_drop",  64'(drop_cnt),  64'd0);
      check_eq("t6_rst_data",  64'(rec_data),  64'd0);
      tick();
      reset = 1'b0;
      repeat (6) tick();
      check_eq("t6_post_valid", 64'(rec_valid), 64'd0);
      check_eq("t6_post_drop",  64'(drop_cnt),  64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
